// File: rtl/sha256_stream_wrapper.sv
// rtl/sha256_stream_wrapper.sv - Avalon-MM SHA-256 block streamer with word FIFO; optional IRQ via SHA_WRAP_IRQ_EN

// Word FIFO: registered pointers, combinational head, push accepted on full only alongside a pop
module sha256_word_fifo #(
   parameter int DEPTH = 32,
   parameter int LVL_W = 6
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic             clear,
   input  logic             push,
   input  logic [31:0]      push_data,
   input  logic             pop,
   output logic [31:0]      head,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             full,
   output logic             overflow
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (level == '0);
   assign full     = (level == LVL_W'(DEPTH));
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign overflow = push && !push_ok;
   assign head     = mem[rd_ptr];

   // storage array, written on every accepted push
   always_ff @(posedge iClk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge iClk) begin
      if (iReset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end
endmodule

// Bus slave, block sequencer and digest capture
module sha256_stream_wrapper #(
   parameter int FIFO_DEPTH  = 32,
   parameter int BLOCK_WORDS = 16,
   parameter int DIGEST_W    = 256,
   parameter int ADDR_W      = 5
) (
   input  logic                iClk,
   input  logic                iReset,
   input  logic                iChipselect_n,
   input  logic                iWrite_n,
   input  logic                iRead_n,
   input  logic [ADDR_W-1:0]   iAddress,
   input  logic [31:0]         iData,
   output logic [31:0]         oData,
   output logic                oIrq,
   output logic                oCoreStart,
   output logic                oCoreFirst,
   output logic                oCoreValid,
   output logic [31:0]         oCoreData,
   input  logic                iCoreDone,
   input  logic [DIGEST_W-1:0] iCoreDigest
);
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W     = $clog2(BLOCK_WORDS + 1);
   localparam int DIG_WORDS = DIGEST_W / 32;

   typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} state_t;

   state_t              state;
   logic [CNT_W-1:0]    word_cnt;
   logic                ctrl_en;
   logic                ctrl_irq_en;
   logic                first_pend;
   logic                sts_done;
   logic                sts_ovf;
   logic [DIGEST_W-1:0] digest_q;
   logic [31:0]         rd_mux;

   logic                bus_wr;
   logic                bus_rd;
   logic                wr_ctrl;
   logic                wr_data;
   logic                wr_status;
   logic                flush;
   logic                pop;
   logic                core_done;
   logic [31:0]         fifo_head;
   logic [LVL_W-1:0]    fifo_level;
   logic                fifo_empty;
   logic                fifo_full;
   logic                fifo_ovf;

   assign bus_wr    = !iChipselect_n && !iWrite_n;
   assign bus_rd    = !iChipselect_n && !iRead_n;
   assign wr_ctrl   = bus_wr && (iAddress == ADDR_W'(0));
   assign wr_data   = bus_wr && (iAddress == ADDR_W'(1));
   assign wr_status = bus_wr && (iAddress == ADDR_W'(2));
   assign flush     = wr_ctrl && iData[3];
   assign core_done = (state == WAIT) && iCoreDone;
   // word 0 leaves the FIFO while in START, the rest one per STREAM cycle
   assign pop       = !flush && ((state == START) ||
                      ((state == STREAM) && (word_cnt != CNT_W'(BLOCK_WORDS - 1))));

   sha256_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .iClk      (iClk),
      .iReset    (iReset),
      .clear     (flush),
      .push      (wr_data && !flush),
      .push_data (iData),
      .pop       (pop),
      .head      (fifo_head),
      .level     (fifo_level),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .overflow  (fifo_ovf)
   );

   // control enable, sticky status flags and digest capture (set beats clear)
   always_ff @(posedge iClk) begin
      if (iReset) begin
         ctrl_en  <= 1'b0;
         sts_ovf  <= 1'b0;
         sts_done <= 1'b0;
         digest_q <= '0;
      end else begin
         if (wr_ctrl) ctrl_en <= iData[0];
         if (fifo_ovf) sts_ovf <= 1'b1;
         else if (wr_status && iData[2]) sts_ovf <= 1'b0;
         if (core_done) begin
            sts_done <= 1'b1;
            digest_q <= iCoreDigest;
         end else if (wr_status && iData[0]) begin
            sts_done <= 1'b0;
         end
      end
   end

`ifdef SHA_WRAP_IRQ_EN
   // interrupt enable bit and registered interrupt level
   always_ff @(posedge iClk) begin
      if (iReset) begin
         ctrl_irq_en <= 1'b0;
         oIrq        <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_irq_en <= iData[2];
         oIrq <= sts_done && ctrl_irq_en;
      end
   end
`else
   assign ctrl_irq_en = 1'b0;
   assign oIrq        = 1'b0;
`endif

   // block sequencer: IDLE -> START -> STREAM -> WAIT, flush overrides everything
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state      <= IDLE;
         word_cnt   <= '0;
         first_pend <= 1'b1;
         oCoreStart <= 1'b0;
         oCoreFirst <= 1'b0;
         oCoreValid <= 1'b0;
         oCoreData  <= '0;
      end else begin
         oCoreStart <= 1'b0;
         oCoreFirst <= 1'b0;
         if (flush) begin
            state      <= IDLE;
            word_cnt   <= '0;
            first_pend <= 1'b1;
            oCoreValid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ctrl_en && (fifo_level >= LVL_W'(BLOCK_WORDS))) begin
                     state      <= START;
                     oCoreStart <= 1'b1;
                     oCoreFirst <= first_pend;
                  end
               end
               START: begin
                  state      <= STREAM;
                  first_pend <= 1'b0;
                  word_cnt   <= '0;
                  oCoreValid <= 1'b1;
                  oCoreData  <= fifo_head;
               end
               STREAM: begin
                  if (word_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                     state      <= WAIT;
                     oCoreValid <= 1'b0;
                  end else begin
                     word_cnt  <= word_cnt + CNT_W'(1);
                     oCoreData <= fifo_head;
                  end
               end
               WAIT: begin
                  if (iCoreDone) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
            // a NEW_MSG write wins over the clear on leaving START
            if (wr_ctrl && iData[1]) first_pend <= 1'b1;
         end
      end
   end

   // read mux: CTRL, STATUS and digest words, everything else reads zero
   always_comb begin
      rd_mux = '0;
      if (iAddress == ADDR_W'(0)) begin
         rd_mux = {28'd0, 1'b0, ctrl_irq_en, 1'b0, ctrl_en};
      end else if (iAddress == ADDR_W'(2)) begin
         rd_mux = {{(16 - LVL_W){1'b0}}, fifo_level, 11'd0,
                   fifo_full, fifo_empty, sts_ovf, (state != IDLE), sts_done};
      end
      for (int k = 0; k < DIG_WORDS; k++) begin
         if (iAddress == ADDR_W'(8 + k)) rd_mux = digest_q[DIGEST_W - 1 - 32 * k -: 32];
      end
   end

   // registered read data, held when no read strobe
   always_ff @(posedge iClk) begin
      if (iReset) oData <= '0;
      else if (bus_rd) oData <= rd_mux;
   end
endmodule

// File: tb/tb_sha256_stream_wrapper.sv
// tb/tb_sha256_stream_wrapper.sv - directed scoreboard bench for sha256_stream_wrapper
module tb_sha256_stream_wrapper;
   localparam int DW = 256;
`ifdef SHA_WRAP_IRQ_EN
   localparam logic [31:0] IRQ_EXP  = 32'd1;
   localparam logic [31:0] CTRL_IRQ = 32'h5;
`else
   localparam logic [31:0] IRQ_EXP  = 32'd0;
   localparam logic [31:0] CTRL_IRQ = 32'h1;
`endif

   logic          iClk = 1'b0;
   logic          iReset = 1'b1;
   logic          iChipselect_n = 1'b1;
   logic          iWrite_n = 1'b1;
   logic          iRead_n = 1'b1;
   logic [4:0]    iAddress = '0;
   logic [31:0]   iData = '0;
   logic [31:0]   oData;
   logic          oIrq;
   logic          oCoreStart;
   logic          oCoreFirst;
   logic          oCoreValid;
   logic [31:0]   oCoreData;
   logic          iCoreDone = 1'b0;
   logic [DW-1:0] iCoreDigest = '0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int words_seen = 0;
   int last_start_cyc = -10;
   int last_valid_cyc = -10;
   int done_cyc = 0;
   logic [31:0] exp_q[$];
   logic        exp_first_q[$];

   logic [DW-1:0] dg_abc = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   logic [DW-1:0] dg1 = 256'h01010101_02020202_03030303_04040404_05050505_06060606_07070707_08080808;
   logic [DW-1:0] dg2 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
   logic [DW-1:0] dg3 = {8{32'hdeadbeef}};
   logic [DW-1:0] dg4 = {8{32'hcafef00d}};

   sha256_stream_wrapper dut (
      .iClk          (iClk),
      .iReset        (iReset),
      .iChipselect_n (iChipselect_n),
      .iWrite_n      (iWrite_n),
      .iRead_n       (iRead_n),
      .iAddress      (iAddress),
      .iData         (iData),
      .oData         (oData),
      .oIrq          (oIrq),
      .oCoreStart    (oCoreStart),
      .oCoreFirst    (oCoreFirst),
      .oCoreValid    (oCoreValid),
      .oCoreData     (oCoreData),
      .iCoreDone     (iCoreDone),
      .iCoreDigest   (iCoreDigest)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // core-side monitor: pops the scoreboard on every start and every valid word
   always @(negedge iClk) begin
      if (!iReset) begin
         if (oCoreStart) begin
            last_start_cyc = cyc;
            check("start_expected", 32'(exp_first_q.size() != 0), 32'd1);
            if (exp_first_q.size() != 0) check("core_first", {31'd0, oCoreFirst}, {31'd0, exp_first_q.pop_front()});
         end
         if (oCoreValid) begin
            check("valid_timing", 32'((cyc == last_valid_cyc + 1) || (cyc == last_start_cyc + 1)), 32'd1);
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("core_word", oCoreData, exp_q.pop_front());
            words_seen++;
            last_valid_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      iChipselect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
      tick();
      iChipselect_n = 1'b1; iWrite_n = 1'b1;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
      iChipselect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
      tick();
      iChipselect_n = 1'b1; iRead_n = 1'b1;
      check(tag, oData, exp);
   endtask

   task automatic push_word(input logic [31:0] d, input bit expect_out);
      if (expect_out) exp_q.push_back(d);
      bus_write(5'h01, d);
   endtask

   task automatic wait_words(input int target, input string tag);
      int n = 0;
      while (words_seen < target && n < 300) begin
         tick();
         n++;
      end
      check(tag, 32'(words_seen >= target), 32'd1);
   endtask

   task automatic core_done(input logic [DW-1:0] dg);
      iCoreDone = 1'b1; iCoreDigest = dg;
      tick();
      iCoreDone = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) tick();
      iReset = 1'b0;
      check("rst_start", {31'd0, oCoreStart}, 32'd0);
      check("rst_first", {31'd0, oCoreFirst}, 32'd0);
      check("rst_valid", {31'd0, oCoreValid}, 32'd0);
      check("rst_cdata", oCoreData, 32'd0);
      check("rst_irq", {31'd0, oIrq}, 32'd0);
      check("rst_odata", oData, 32'd0);
      read_check("rst_ctrl", 5'h00, 32'h0);
      read_check("rst_status", 5'h02, 32'h8);
      read_check("rst_dig0", 5'h08, 32'h0);
      read_check("rst_dig7", 5'h0F, 32'h0);

      // "abc" single block, first of message
      exp_first_q.push_back(1'b1);
      bus_write(5'h00, 32'h3);
      read_check("ctrl_en", 5'h00, 32'h1);
      for (int i = 0; i < 16; i++)
         push_word((i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0, 1'b1);
      wait_words(16, "abc_words");
      read_check("abc_wait_status", 5'h02, 32'h0000000A);
      core_done(dg_abc);
      read_check("abc_done_status", 5'h02, 32'h9);
      read_check("abc_dig0", 5'h08, 32'hba7816bf);
      read_check("abc_dig7", 5'h0F, 32'hf20015ad);
      bus_write(5'h02, 32'h1);
      read_check("abc_clr_status", 5'h02, 32'h8);

      // two queued blocks, second follows 2 cycles after the first done
      bus_write(5'h00, 32'h0);
      for (int i = 0; i < 32; i++) push_word(32'h1000_0000 + 32'(i * 7), 1'b1);
      read_check("full_status", 5'h02, 32'h00200010);
      exp_first_q.push_back(1'b1);
      exp_first_q.push_back(1'b0);
      bus_write(5'h00, 32'h3);
      wait_words(32, "blk1_words");
      read_check("blk1_wait_status", 5'h02, 32'h00100002);
      iCoreDone = 1'b1; iCoreDigest = dg1;
      iChipselect_n = 1'b0; iWrite_n = 1'b0; iAddress = 5'h02; iData = 32'h1;
      done_cyc = cyc;
      tick();
      iChipselect_n = 1'b1; iWrite_n = 1'b1; iCoreDone = 1'b0;
      read_check("set_wins_status", 5'h02, 32'h00100001);
      read_check("blk1_dig0", 5'h08, 32'h01010101);
      wait_words(48, "blk2_words");
      check("second_start_gap", 32'(last_start_cyc - done_cyc), 32'd2);
      core_done(dg2);
      read_check("blk2_status", 5'h02, 32'h9);
      read_check("blk2_dig7", 5'h0F, 32'h88888888);
      read_check("blk2_dig0", 5'h08, 32'h11111111);
      read_check("beyond_digest", 5'h10, 32'h0);
      read_check("unmapped", 5'h03, 32'h0);
      bus_write(5'h02, 32'h1);
      core_done(dg3);
      read_check("stray_done_status", 5'h02, 32'h8);
      read_check("stray_done_dig", 5'h0F, 32'h88888888);

      // overflow with EN=0
      bus_write(5'h00, 32'h0);
      for (int i = 0; i < 33; i++) push_word(32'hABCD_0000 + 32'(i), 1'b0);
      read_check("ovf_status", 5'h02, 32'h00200014);
      bus_write(5'h02, 32'h4);
      read_check("ovf_clr_status", 5'h02, 32'h00200010);
      bus_write(5'h00, 32'h8);
      read_check("flush_status", 5'h02, 32'h8);

      // flush in the middle of a stream
      for (int i = 0; i < 16; i++) push_word(32'h5000_0000 + 32'(i), i < 6);
      exp_first_q.push_back(1'b1);
      bus_write(5'h00, 32'h1);
      wait_words(53, "flush_blk_words");
      bus_write(5'h00, 32'h9);
      check("flush_valid_drop", {31'd0, oCoreValid}, 32'd0);
      check("flush_word_count", 32'(words_seen), 32'd54);
      read_check("flush_mid_status", 5'h02, 32'h8);

      // next block is first again; interrupt behaviour
      exp_first_q.push_back(1'b1);
      bus_write(5'h00, 32'h5);
      read_check("ctrl_irq", 5'h00, CTRL_IRQ);
      for (int i = 0; i < 16; i++) push_word(32'h7000_0000 + 32'(i * 3), 1'b1);
      wait_words(70, "last_words");
      check("irq_idle", {31'd0, oIrq}, 32'd0);
      core_done(dg4);
      check("irq_d1", {31'd0, oIrq}, 32'd0);
      tick();
      check("irq_d2", {31'd0, oIrq}, IRQ_EXP);
      bus_write(5'h02, 32'h1);
      check("irq_hold", {31'd0, oIrq}, IRQ_EXP);
      tick();
      check("irq_fall", {31'd0, oIrq}, 32'd0);
      read_check("last_dig3", 5'h0B, 32'hcafef00d);

      repeat (3) tick();
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("starts_left", 32'(exp_first_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
